// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states and control bundle
// for the multi-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic    illegal;
    logic    is_j;
    logic    is_jr;
    logic    is_br;
    logic    is_bne;
    logic    is_lw;
    logic    is_sw;
    logic    wr_rd;
    logic    zext;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational decode of opcode/funct into
// control fields plus an illegal-instruction flag.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (1'b1)
      op == OP_RTYPE: begin
        unique case (1'b1)
          funct == FN_ADD: begin
            ctrl.wr_rd = 1'b1;
            ctrl.alu_op = ALU_ADD;
          end
          funct == FN_SUB: begin
            ctrl.wr_rd = 1'b1;
            ctrl.alu_op = ALU_SUB;
          end
          funct == FN_AND: begin
            ctrl.wr_rd = 1'b1;
            ctrl.alu_op = ALU_AND;
          end
          funct == FN_OR: begin
            ctrl.wr_rd = 1'b1;
            ctrl.alu_op = ALU_OR;
          end
          funct == FN_SLT: begin
            ctrl.wr_rd = 1'b1;
            ctrl.alu_op = ALU_SLT;
          end
          funct == FN_JR: ctrl.is_jr = 1'b1;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      op == OP_J:    ctrl.is_j = 1'b1;
      op == OP_BEQ:  ctrl.is_br = 1'b1;
      op == OP_BNE: begin
        ctrl.is_br = 1'b1;
        ctrl.is_bne = 1'b1;
      end
      op == OP_ADDI: ctrl.alu_op = ALU_ADD;
      op == OP_ANDI: begin
        ctrl.zext = 1'b1;
        ctrl.alu_op = ALU_AND;
      end
      op == OP_ORI: begin
        ctrl.zext = 1'b1;
        ctrl.alu_op = ALU_OR;
      end
      op == OP_LW: ctrl.is_lw = 1'b1;
      op == OP_SW: ctrl.is_sw = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core, one unified req/ready memory port.
// Define MIPS_PERF_CNT_EN for perf_cycles/perf_retired counters.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc_out
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_retired
`endif
);

  localparam int AW = ADDR_WIDTH;

  state_t        state, next_state;
  logic [AW-1:0] pc, pc4, pc_nxt;
  logic [31:0]   ir, mdr;
  logic [31:0]   regs [32];
  logic          pc_we, ir_we, mdr_we, rf_we;
  ctrl_t         ctrl;

  logic [4:0]  rs, rt, rd, wb_addr;
  logic [31:0] rs_val, rt_val, imm_ext, opb;
  logic [31:0] alu_res, ea, jt32, br_off, wb_data;
  logic        taken;

  mips_mc_decode u_dec (
    .op    (ir[31:26]),
    .funct (ir[5:0]),
    .ctrl  (ctrl)
  );

  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];

  assign rs_val  = regs[rs];
  assign rt_val  = regs[rt];
  assign imm_ext = ctrl.zext ? {16'h0, ir[15:0]}
                             : {{16{ir[15]}}, ir[15:0]};
  assign opb     = ctrl.wr_rd ? rt_val : imm_ext;
  assign ea      = rs_val + imm_ext;
  assign pc4     = pc + AW'(4);
  assign br_off  = {imm_ext[29:0], 2'b00};
  assign taken   = (rs_val == rt_val) ^ ctrl.is_bne;

  // Jump keeps the top nibble of pc4, then truncates to AW
  always_comb begin
    jt32 = 32'(pc4);
    jt32[27:0] = {ir[25:0], 2'b00};
  end

  always_comb begin
    unique case (ctrl.alu_op)
      ALU_ADD: alu_res = rs_val + opb;
      ALU_SUB: alu_res = rs_val - opb;
      ALU_AND: alu_res = rs_val & opb;
      ALU_OR:  alu_res = rs_val | opb;
      ALU_SLT: alu_res = {31'b0, $signed(rs_val) < $signed(opb)};
      default: alu_res = rs_val + opb;
    endcase
  end

  assign wb_addr = ctrl.wr_rd ? rd : rt;
  assign wb_data = ctrl.is_lw ? mdr : alu_res;

  always_comb begin
    next_state = state;
    pc_nxt = pc4;
    pc_we  = 1'b0;
    ir_we  = 1'b0;
    mdr_we = 1'b0;
    rf_we  = 1'b0;
    unique case (state)
      FETCH: begin
        if (mem_ready) begin
          ir_we = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (ctrl.illegal) begin
          next_state = HALT;
        end else if (ctrl.is_j) begin
          pc_we = 1'b1;
          pc_nxt = jt32[AW-1:0];
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          ctrl.is_jr: begin
            if (rs_val[1:0] != 2'b00) begin
              next_state = HALT;
            end else begin
              pc_we = 1'b1;
              pc_nxt = rs_val[AW-1:0];
              next_state = FETCH;
            end
          end
          ctrl.is_br: begin
            pc_we = 1'b1;
            if (taken) pc_nxt = pc4 + br_off[AW-1:0];
            next_state = FETCH;
          end
          ctrl.is_lw | ctrl.is_sw: begin
            next_state = (ea[1:0] != 2'b00) ? HALT : MEM;
          end
          default: next_state = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (ctrl.is_lw) begin
            mdr_we = 1'b1;
            next_state = WB;
          end else begin
            pc_we = 1'b1;
            next_state = FETCH;
          end
        end
      end
      WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        next_state = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      ir  <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pc_we)  pc  <= pc_nxt;
      if (ir_we)  ir  <= mem_rdata;
      if (mdr_we) mdr <= mem_rdata;
      if (rf_we && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end
  end

  assign mem_req   = ~rst & ((state == FETCH) | (state == MEM));
  assign mem_we    = (state == MEM) & ctrl.is_sw;
  assign mem_addr  = (state == MEM) ? ea[AW-1:0] : pc;
  assign mem_wdata = mem_we ? rt_val : '0;
  assign halted    = (state == HALT);
  assign pc_out    = pc;

`ifdef MIPS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (state != HALT) perf_cycles <= perf_cycles + 32'd1;
      if (next_state == FETCH && state != FETCH)
        perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: store
// scoreboard, fetch-latency log and handshake checks.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC = 32'h100;

  localparam logic [5:0] O_J = 6'd2, O_BEQ = 6'd4, O_BNE = 6'd5;
  localparam logic [5:0] O_ADDI = 6'd8, O_ANDI = 6'd12;
  localparam logic [5:0] O_ORI = 6'd13, O_LW = 6'd35, O_SW = 6'd43;
  localparam logic [5:0] F_JR = 6'd8, F_ADD = 6'd32, F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_SLT = 6'd42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  mips_multicycle_core #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .halted    (halted),
    .pc_out    (pc_out)
`ifdef MIPS_PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_retired (perf_retired)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:63];
  int waits = 0;
  int wcnt = 0;
  int cyc = 0;

  assign mem_ready = mem_req && (wcnt >= waits);
  assign mem_rdata = (mem_addr < 32'h100) ? dmem[mem_addr[7:2]]
                                          : imem[mem_addr[11:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ready && mem_we && mem_addr < 32'h100)
      dmem[mem_addr[7:2]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct { logic [31:0] addr; int c; } rd_t;
  st_t sb[$];
  rd_t rlog[$];

  logic        prev_stall = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  always @(negedge clk) begin
    st_t e;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, p_addr);
        check("hold_we", mem_we, p_we);
        check("hold_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          if (sb.size() > 0) e = sb.pop_front();
          else e = '{32'hFFFF_FFFF, 32'hDEAD_BEEF};
          check("st_addr", mem_addr, e.addr);
          check("st_data", mem_wdata, e.data);
        end else begin
          rlog.push_back('{mem_addr, cyc});
        end
      end
    end
    prev_stall = !rst && mem_req && !mem_ready;
    p_addr = mem_addr;
    p_we = mem_we;
    p_wdata = mem_wdata;
  end

  function automatic logic [31:0] ri(logic [5:0] op, int rs, int rt,
                                     int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rr(int rs, int rt, int rd,
                                     logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] jj(int idx);
    return {O_J, 26'(idx)};
  endfunction

  function automatic int nth(logic [31:0] a, int n);
    int k = 0;
    foreach (rlog[i]) begin
      if (rlog[i].addr == a) begin
        k++;
        if (k == n) return rlog[i].c;
      end
    end
    return -1;
  endfunction

  logic [31:0] pa;

  task automatic emit(input logic [31:0] w);
    imem[pa[11:2]] = w;
    pa += 32'd4;
  endtask

  task automatic expect_st(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{a, d});
  endtask

  task automatic begin_prog(input int w);
    @(posedge clk);
    #1 rst = 1'b1;
    waits = w;
    sb.delete();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    pa = RPC;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_out, RPC);
    check("rst_addr", mem_addr, RPC);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
`ifdef MIPS_PERF_CNT_EN
    check("rst_pcyc", perf_cycles, 0);
    check("rst_pret", perf_retired, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    rlog.delete();
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, RPC);
    check("first_we", mem_we, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", mem_req, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_pc", pc_out, RPC);
    check("mid_addr", mem_addr, RPC);
    check("mid_req", mem_req, 1);
    check("mid_we", mem_we, 0);
`ifdef MIPS_PERF_CNT_EN
    check("mid_pret", perf_retired, 0);
`endif
  endtask

  task automatic wait_sb(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic check_halt(input string tag, input logic [31:0] fpc);
    int n = 0;
    int reqs = 0;
    while (!halted && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, halted, 1);
    check({tag, "_pc"}, pc_out, fpc);
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check({tag, "_noreq"}, reqs, 0);
    check({tag, "_hold"}, halted, 1);
    check({tag, "_pc2"}, pc_out, fpc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    // ALU ops, $0 rule, zero-wait latency
    begin_prog(0);
    emit(ri(O_ADDI, 0, 1, 5));
    emit(ri(O_ADDI, 0, 2, -3));
    emit(rr(1, 2, 3, F_ADD));
    emit(rr(2, 1, 4, F_SLT));
    emit(ri(O_ADDI, 0, 0, 7));
    emit(rr(1, 2, 7, F_SUB));
    emit(rr(1, 2, 8, F_AND));
    emit(rr(1, 2, 9, F_OR));
    emit(ri(O_ANDI, 2, 10, 16'hFFFF));
    emit(ri(O_ORI, 0, 11, 16'h8000));
    emit(ri(O_SW, 0, 3, 'h10));
    emit(ri(O_SW, 0, 4, 'h14));
    emit(ri(O_SW, 0, 0, 'h18));
    emit(ri(O_SW, 0, 7, 'h1C));
    emit(ri(O_SW, 0, 8, 'h20));
    emit(ri(O_SW, 0, 9, 'h24));
    emit(ri(O_SW, 0, 10, 'h28));
    emit(ri(O_SW, 0, 11, 'h2C));
    emit(rr(1, 2, 12, F_SLT));
    emit(ri(O_SW, 0, 12, 'h30));
    emit(ri(O_BEQ, 0, 0, -1));
    expect_st(32'h10, 32'd2);
    expect_st(32'h14, 32'd1);
    expect_st(32'h18, 32'd0);
    expect_st(32'h1C, 32'd8);
    expect_st(32'h20, 32'd5);
    expect_st(32'h24, 32'hFFFF_FFFD);
    expect_st(32'h28, 32'h0000_FFFD);
    expect_st(32'h2C, 32'h0000_8000);
    expect_st(32'h30, 32'd0);
    release_rst();
`ifdef MIPS_PERF_CNT_EN
    n = 0;
    while (!(mem_req && mem_addr == 32'h114) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("perf_ret5", perf_retired, 5);
`endif
    wait_sb("sb_alu", 400);
    repeat (12) @(negedge clk);
    check("lat_alu", nth(32'h104, 1) - nth(32'h100, 1), 4);
    check("lat_sw0", nth(32'h12C, 1) - nth(32'h128, 1), 4);
    check("lat_beq", nth(32'h150, 2) - nth(32'h150, 1), 3);
    check("loop_pc", pc_out, 32'h150);

    // Load/store with three wait states
    begin_prog(3);
    emit(ri(O_ADDI, 0, 1, 5));
    emit(ri(O_SW, 0, 1, 8));
    emit(ri(O_LW, 0, 5, 8));
    emit(ri(O_SW, 0, 5, 'hC));
    emit(ri(O_BEQ, 0, 0, -1));
    expect_st(32'h8, 32'd5);
    expect_st(32'hC, 32'd5);
    release_rst();
    wait_sb("sb_ldst", 400);
    repeat (4) @(negedge clk);
    check("lat_sw3", nth(32'h108, 1) - nth(32'h104, 1), 10);
    check("lat_lw3", nth(32'h10C, 1) - nth(32'h108, 1), 11);

    // Branches and jumps
    begin_prog(0);
    emit(ri(O_ADDI, 0, 1, 1));
    emit(ri(O_BNE, 1, 1, 5));
    emit(ri(O_ADDI, 0, 6, 'h200));
    emit(rr(6, 0, 0, F_JR));
    pa = 32'h11C;
    emit(ri(O_SW, 0, 1, 'h34));
    pa = 32'h200;
    emit(ri(O_SW, 0, 1, 'h20));
    emit(ri(O_BEQ, 1, 1, 1));
    emit(ri(O_SW, 0, 6, 'h30));
    emit(jj('h90));
    pa = 32'h240;
    emit(ri(O_SW, 0, 6, 'h24));
    emit(jj('h91));
    expect_st(32'h20, 32'd1);
    expect_st(32'h24, 32'h200);
    release_rst();
    wait_sb("sb_br", 200);
    repeat (8) @(negedge clk);
    check("lat_bne", nth(32'h108, 1) - nth(32'h104, 1), 3);
    check("lat_jr", nth(32'h200, 1) - nth(32'h10C, 1), 3);
    check("beq_skip", nth(32'h208, 1), 32'hFFFF_FFFF);
    check("lat_j", nth(32'h240, 1) - nth(32'h20C, 1), 2);
    check("lat_jself", nth(32'h244, 2) - nth(32'h244, 1), 2);
    check("j_pc", pc_out, 32'h244);

    // Misaligned load halts
    begin_prog(0);
    emit(ri(O_ADDI, 0, 1, 6));
    emit(ri(O_LW, 1, 2, 0));
    release_rst();
    check_halt("halt_ea", 32'h104);

    // Illegal opcode halts after a restart from reset
    begin_prog(2);
    emit(ri(O_SW, 0, 0, 'h40));
    emit({6'h3F, 26'h0});
    expect_st(32'h40, 32'd0);
    release_rst();
    wait_sb("sb_halt", 100);
    check_halt("halt_op", 32'h104);

    // Reset during stalled store and stalled fetch
    begin_prog(3);
    emit(ri(O_ADDI, 1, 1, 9));
    emit(ri(O_SW, 0, 1, 'h50));
    emit(jj('h40));
    expect_st(32'h50, 32'd9);
    release_rst();
    wait_sb("sb_rst1", 200);
    n = 0;
    while (!(mem_req && mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("st2_seen", mem_req && mem_we, 1);
    check("lat_j40", nth(32'h100, 2) - nth(32'h108, 1), 5);
    mid_reset();
    expect_st(32'h50, 32'd9);
    wait_sb("sb_rst2", 200);
    n = 0;
    while (!(mem_req && !mem_we && !mem_ready &&
             mem_addr == 32'h104) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("fetch_stall", mem_addr, 32'h104);
    mid_reset();
    expect_st(32'h50, 32'd9);
    wait_sb("sb_rst3", 200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
